// File: rtl/dm_trace_ram_pkg.sv
// Shared types and helpers for the trace-capturing data memory.
package dm_trace_ram_pkg;

  localparam int DM_WORDS_DEF    = 4096;
  localparam int TRACE_DEPTH_DEF = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  // Replace each enabled byte lane of old_word with the matching lane of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (byteen[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_trace_ram_if.sv
// Core data port plus trace-record stream between the core side and the data memory.
interface dm_trace_ram_if;

  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;

  // Trace stream: a record transfers on every rising edge where trace_valid
  // and trace_ready are both high; while trace_valid is high and trace_ready
  // is low the head fields hold stable. trace_valid never waits on trace_ready.
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        addr_err;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );

endinterface

// File: rtl/dm_trace_ram_trace_fifo.sv
// Synchronous FIFO of trace records with a sticky overflow flag for dropped pushes.
module dm_trace_ram_trace_fifo
  import dm_trace_ram_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  trace_rec_t push_rec,
  input  logic       ready,
  output logic       valid,
  output trace_rec_t head,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  trace_rec_t    entries [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          do_push;

  assign full  = (count == FULL_COUNT);
  assign valid = (count != '0);
  assign head  = entries[rd_ptr];
  assign pop   = ready && valid;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset && do_push) entries[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/dm_trace_ram.sv
// Byte-enabled word data memory that logs every committed store into a trace FIFO.
module dm_trace_ram
  import dm_trace_ram_pkg::*;
#(
  parameter int DM_WORDS    = DM_WORDS_DEF,
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEF
) (
  input logic          clk,
  input logic          reset,
  dm_trace_ram_if.slave bus
);

  localparam int          IW        = $clog2(DM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DM_WORDS * 4);

  logic [31:0] mem [DM_WORDS];
  logic [IW-1:0] index;
  logic          in_range;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          store;
  logic          access_err;
  logic          err_q;
  trace_rec_t    push_rec;
  trace_rec_t    head;

  assign index    = bus.m_data_addr[IW+1:2];
  assign in_range = (bus.m_data_addr < MEM_BYTES);
  assign old_word = mem[index];
  assign merged   = merge_bytes(old_word, bus.m_data_wdata, bus.m_data_byteen);
  assign store    = (|bus.m_data_byteen) && in_range;
  // Zero PC marks reset/bubble cycles, whose stale addresses must not flag errors.
  assign access_err = !in_range && ((|bus.m_data_byteen) || (bus.m_inst_addr != '0));

  assign bus.m_data_rdata = in_range ? old_word : '0;
  assign bus.addr_err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (store) begin
      mem[index] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           err_q <= 1'b0;
    else if (access_err) err_q <= 1'b1;
  end

  assign push_rec = '{pc:   bus.m_inst_addr,
                      addr: {bus.m_data_addr[31:2], 2'b00},
                      data: merged};

  dm_trace_ram_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (store),
    .push_rec (push_rec),
    .ready    (bus.trace_ready),
    .valid    (bus.trace_valid),
    .head     (head),
    .overflow (bus.trace_overflow)
  );

  assign bus.trace_pc   = head.pc;
  assign bus.trace_addr = head.addr;
  assign bus.trace_data = head.data;

endmodule

// File: tb/tb_dm_trace_ram.sv
// Bench for dm_trace_ram: table vectors, hand sequences for FIFO corners, randomized run vs a model.
module tb_dm_trace_ram;

  localparam int WORDS = 4096;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_trace_ram_if bus();
  dm_trace_ram dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] ref_mem [WORDS];
  logic [95:0] exp_q[$];
  logic        ref_ovf;
  logic        ref_err;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_in(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] pc, input logic ready);
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = ready;
  endtask

  // Compare DUT against the model for the current inputs, advance the model
  // by one clock using the memory/queue rules, then cross the edge.
  task automatic step();
    logic [31:0] a, old, mask, merged;
    bit in_range;
    #1;
    a        = bus.m_data_addr;
    in_range = (a < 32'(WORDS * 4));
    old      = in_range ? ref_mem[a[13:2]] : 32'h0;
    if (!reset) begin
      check("rdata", {64'h0, bus.m_data_rdata}, {64'h0, old});
      check("trace_valid", {95'h0, bus.trace_valid}, {95'h0, exp_q.size() != 0});
      if (exp_q.size() != 0)
        check("trace_head", {bus.trace_pc, bus.trace_addr, bus.trace_data}, exp_q[0]);
      check("trace_overflow", {95'h0, bus.trace_overflow}, {95'h0, ref_ovf});
      check("addr_err", {95'h0, bus.addr_err}, {95'h0, ref_err});
    end
    if (reset) begin
      foreach (ref_mem[i]) ref_mem[i] = 32'h0;
      exp_q.delete();
      ref_ovf = 1'b0;
      ref_err = 1'b0;
    end else begin
      mask = 32'h0;
      for (int k = 0; k < 4; k++)
        if (bus.m_data_byteen[k]) mask = mask | (32'hFF << (8 * k));
      merged = (old & ~mask) | (bus.m_data_wdata & mask);
      if (bus.trace_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (!in_range && (bus.m_data_byteen != 4'h0 || bus.m_inst_addr != 32'h0)) ref_err = 1'b1;
      if (in_range && bus.m_data_byteen != 4'h0) begin
        ref_mem[a[13:2]] = merged;
        if (exp_q.size() < DEPTH) exp_q.push_back({bus.m_inst_addr, a & ~32'h3, merged});
        else ref_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] pc, input logic ready);
    set_in(addr, wdata, be, pc, ready);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [95:0] exp);
    check(name, {bus.trace_pc, bus.trace_addr, bus.trace_data}, exp);
  endtask

  vec_t        vecs[6];
  logic [95:0] recs[DEPTH + 1];
  logic [31:0] wd;

  initial begin
    set_in(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_valid", {95'h0, bus.trace_valid}, 96'h0);
    check("reset_flags", {94'h0, bus.trace_overflow, bus.addr_err}, 96'h0);

    // Store then read back the word; expected words are hand-computed merges.
    vecs[0] = '{32'h10,   32'h12345678, 4'b1111, 32'h3000, 32'h12345678, 1'b0};
    vecs[1] = '{32'h11,   32'h0000AB00, 4'b0010, 32'h3004, 32'h1234AB78, 1'b0};
    vecs[2] = '{32'h12,   32'hCDEF0000, 4'b1100, 32'h3008, 32'hCDEFAB78, 1'b0};
    vecs[3] = '{32'h4000, 32'hFFFFFFFF, 4'b1111, 32'h300C, 32'h0,        1'b1};
    vecs[4] = '{32'h4004, 32'h0,        4'b0000, 32'h3010, 32'h0,        1'b1};
    vecs[5] = '{32'h10,   32'h0,        4'b0000, 32'h0,    32'hCDEFAB78, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].pc, 1'b0);
      set_in(vecs[i].addr & ~32'h3, 32'h0, 4'h0, 32'h0, 1'b0);
      #1;
      check("vec_rdata", {64'h0, bus.m_data_rdata}, {64'h0, vecs[i].exp_word});
      check("vec_err", {95'h0, bus.addr_err}, {95'h0, vecs[i].exp_err});
      step();
    end
    check_head("rec0", {32'h3000, 32'h10, 32'h12345678});
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    check_head("rec1", {32'h3004, 32'h10, 32'h1234AB78});
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    check_head("rec2", {32'h3008, 32'h10, 32'hCDEFAB78});
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    check("drained_valid", {95'h0, bus.trace_valid}, 96'h0);

    // Nine stores into an 8-deep FIFO with no consumer: last one is dropped.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      wd = $urandom;
      recs[i] = {32'h4000 + 32'(i * 4), 32'h100 + 32'(i * 4), wd};
      drive(32'h100 + 32'(i * 4), wd, 4'hF, 32'h4000 + 32'(i * 4), 1'b0);
    end
    check("full_valid", {95'h0, bus.trace_valid}, 96'h1);
    check("full_overflow", {95'h0, bus.trace_overflow}, 96'h1);
    for (int i = 0; i < DEPTH; i++) begin
      check_head("drain_order", recs[i]);
      drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    end
    check("after_drain_valid", {95'h0, bus.trace_valid}, 96'h0);

    // Full FIFO with a pop and a push in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      recs[i] = {32'h5000 + 32'(i * 4), 32'h200 + 32'(i * 4), 32'hA0 + 32'(i)};
      drive(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 32'h5000 + 32'(i * 4), 1'b0);
    end
    recs[DEPTH] = {32'h6000, 32'h300, 32'h00C0FFEE};
    drive(32'h302, 32'h00C0FFEE, 4'hF, 32'h6000, 1'b1);
    check("pushpop_overflow", {95'h0, bus.trace_overflow}, 96'h0);
    for (int i = 1; i <= DEPTH; i++) begin
      check_head("pushpop_order", recs[i]);
      drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1);
    end
    check("pushpop_empty", {95'h0, bus.trace_valid}, 96'h0);

    // Reset while records are queued, memory is dirty and both flags are set.
    for (int i = 0; i < DEPTH + 3; i++)
      drive(32'h10, $urandom, 4'hF, 32'h7000 + 32'(i * 4), 1'b0);
    drive(32'h8000, 32'h0, 4'h0, 32'h7100, 1'b0);
    check("pre_reset_flags", {94'h0, bus.trace_overflow, bus.addr_err}, 96'h3);
    do_reset();
    set_in(32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    #1;
    check("post_reset_rdata", {64'h0, bus.m_data_rdata}, 96'h0);
    check("post_reset_valid", {95'h0, bus.trace_valid}, 96'h0);
    check("post_reset_flags", {94'h0, bus.trace_overflow, bus.addr_err}, 96'h0);
    step();

    // Randomized traffic over a small address window with occasional out-of-range accesses.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, pc;
      a  = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 255))
                                       : 32'($urandom_range(0, 255));
      pc = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      reset = ($urandom_range(0, 149) == 0);
      drive(a, $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
            pc, $urandom_range(0, 2) == 0);
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_trace_ram.md
Name: dm_trace_ram

Overview:
- Synthesizable data memory that sits directly downstream of the `mips` core's data port.
- Consumes `m_data_addr`, `m_data_wdata`, `m_data_byteen` and `m_inst_addr`, and returns `m_data_rdata`.
- Merges byte-enabled stores into word memory.
- Queues every committed store as a trace record (pc, aligned address, merged word) in a small FIFO, drained by a valid/ready consumer such as a trace printer or UART.
- Replaces the behavioural memory used in simulation so the core can be checked on hardware.

Parameters:
- DM_WORDS, 4096, number of 32-bit words; must be a power of 2.
- TRACE_DEPTH, 8, trace FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- m_data_addr  in  32  byte address from the core's MEM stage.
- m_data_wdata  in  32  store data, already lane-shifted by the core.
- m_data_byteen  in  4  byte-lane write enables; all zero means no store.
- m_inst_addr  in  32  PC of the instruction in MEM.
- m_data_rdata  out  32  combinational read word.
- trace_valid  out  1  FIFO head is valid.
- trace_ready  in  1  consumer accepts the head this cycle.
- trace_pc  out  32  head record: PC of the store.
- trace_addr  out  32  head record: word-aligned address.
- trace_data  out  32  head record: full merged word as written.
- trace_overflow  out  1  sticky; a trace record was dropped.
- addr_err  out  1  sticky; an access fell outside memory.

Behaviour:

Addressing:
- Word index = `m_data_addr[log2(DM_WORDS)+1:2]`; address bits [1:0] are ignored.
- An address is in range iff `m_data_addr < DM_WORDS*4`.

Read path:
- `m_data_rdata` = mem[index], combinational.
- Out-of-range reads return 0.
- A store in the same cycle is not visible until after the clock edge (read-old).

Write path:
- A store occurs when `|m_data_byteen` is high and the address is in range.
- Merged word = old word with lane k replaced by `m_data_wdata[8k+7:8k]` for each k where `byteen[k]=1`.
- mem[index] takes the merged word at the rising edge.

Out-of-range access:
- An out-of-range store is suppressed, pushes no trace record, and sets `addr_err`.
- An out-of-range access with byteen=0 also sets `addr_err`, but only if `m_inst_addr != 0`. This gate suppresses errors during reset and pipeline bubbles.

Trace FIFO:
- Every performed store pushes {`m_inst_addr`, `m_data_addr & ~3`, merged word}.
- Pop happens when `trace_valid && trace_ready`.
- Full, push, no pop: the record is dropped and `trace_overflow` is set.
- Full, push and pop in the same cycle: both happen; occupancy is unchanged and there is no overflow.
- Empty with `trace_ready` high: no effect.
- Pointers wrap modulo TRACE_DEPTH; the count is held in log2(TRACE_DEPTH)+1 bits.
- Head outputs are combinational from the head entry and hold stable while `trace_valid && !trace_ready`.
- Latency: a store at edge N makes `trace_valid` high after edge N when the FIFO was empty.

Reset (synchronous):
- All memory words are cleared to 0.
- FIFO pointers and count are cleared to 0.
- `trace_valid`=0, `trace_overflow`=0, `addr_err`=0.
- `m_data_rdata` reads 0 after the reset edge.
- Reset overrides any same-cycle store or pop; a reset mid-drain discards all queued records.

Decomposition:
- Shared package:
  - DM_WORDS_DEF=4096, TRACE_DEPTH_DEF=8.
  - `trace_rec_t` struct {pc, addr, data}, 96 bits.
  - Helper function `merge_bytes(old, wdata, byteen)`.
- Sub-module `trace_fifo`: generic synchronous FIFO of `trace_rec_t` with push/pop/full/empty and overflow-sticky logic.
- The top level holds the RAM array, the merge logic and the range check.

Test Plan:
1. Reset, then `sw`: addr 0x10, wdata 0x12345678, byteen 4'b1111, pc 0x3000.
   - Next cycle rdata@0x10 = 0x12345678.
   - Trace record = {0x3000, 0x10, 0x12345678}, `trace_valid`=1.
2. Byte and half merge on word 0x10 holding 0x12345678:
   - `sb` at addr 0x11, wdata 0x0000AB00, byteen 4'b0010 → word reads 0x1234AB78.
   - Then `sh` at 0x12, wdata 0xCDEF0000, byteen 4'b1100 → word reads 0xCDEFAB78.
   - Trace records carry addr 0x10 and these merged words.
3. FIFO full and overflow:
   - With `trace_ready`=0, issue 9 stores → `trace_valid`=1, 8 records held, `trace_overflow`=1.
   - Drain with `trace_ready`=1 → records 1..8 emerge in order, then `trace_valid`=0.
4. Simultaneous push and pop on a full FIFO:
   - `trace_ready`=1 and a store in the same cycle → no overflow, count stays 8.
   - The new record appears at the tail.
5. Out-of-range store: addr 0x4000, byteen 4'b1111.
   - Memory unchanged, no trace record, `addr_err`=1.
   - Read of addr 0x4004 returns 0.
6. Reset mid-operation:
   - With 3 queued records and nonzero memory, assert reset for 1 cycle.
   - Next cycle `trace_valid`=0, rdata@0x10 = 0, both sticky flags = 0.
